// File: rtl/csync_decoder.sv
// csync_decoder: recovers H/V counters, blanking, separated syncs, frame parity and lock from composite sync
// Ports:
//   i_EMU_MCLK        master clock
//   i_MRST            synchronous active-high reset
//   i_EMU_CLK6MPCEN_n pixel clock enable, active low
//   i_CSYNC           composite sync, active-low tip
//   o_HCNTR/o_VCNTR   recovered counters (H 128..511, V 248..511)
//   o_HBLANK_n/o_VBLANK_n/o_HSYNC_n/o_VSYNC_n  decoded from the counters
//   o_VSTART          one-tick pulse on vsync detection
//   o_FRAMEPARITY     toggles on every o_VSTART
//   o_LOCKED          high while locked to the line timing
module csync_decoder #(
    parameter logic [8:0] H_EDGE_VAL = 9'd176,
    parameter int         H_WIN      = 4,
    parameter int         EQ_MAX     = 23,
    parameter int         BROAD_MIN  = 64,
    parameter int         LOCK_CNT   = 4
) (
    input  logic       i_EMU_MCLK,
    input  logic       i_MRST,
    input  logic       i_EMU_CLK6MPCEN_n,
    input  logic       i_CSYNC,
    output logic [8:0] o_HCNTR,
    output logic [8:0] o_VCNTR,
    output logic       o_HBLANK_n,
    output logic       o_VBLANK_n,
    output logic       o_HSYNC_n,
    output logic       o_VSYNC_n,
    output logic       o_VSTART,
    output logic       o_FRAMEPARITY,
    output logic       o_LOCKED
);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
    localparam int              CW      = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0]   LC      = CW'(LOCK_CNT);
    localparam logic [8:0]      W_LO    = H_EDGE_VAL - 9'(H_WIN);
    localparam logic [8:0]      W_HI    = H_EDGE_VAL + 9'(H_WIN);
    localparam logic [8:0]      W_CLOSE = W_HI + 9'd1;
    localparam logic [8:0]      HS_END  = H_EDGE_VAL + 9'd31;
    localparam logic [7:0]      EQ_M    = 8'(EQ_MAX);
    localparam logic [7:0]      BR_M    = 8'(BROAD_MIN);
    localparam logic [7:0]      BR_M1   = 8'(BROAD_MIN - 1);

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_good, r_miss, w_good_next, w_miss_next, w_good_inc, w_miss_inc;
    logic [8:0]    r_h, r_v, w_h_cnt, w_h_next;
    logic [7:0]    r_run;
    logic          r_sync_prev, r_edge_seen, r_line_done, r_broad_seen, r_vstart, r_parity;
    logic          w_ce, w_fall, w_rise, w_win, w_acc, w_load, w_close, w_wrap;
    logic          w_line_start, w_norm, w_vtrig;

    assign w_ce         = ~i_EMU_CLK6MPCEN_n;
    assign w_fall       = r_sync_prev & ~i_CSYNC;
    assign w_rise       = ~r_sync_prev & i_CSYNC;
    assign w_win        = (r_h >= W_LO) && (r_h <= W_HI);
    assign w_acc        = w_fall && w_win;
    // Unlocked, any falling edge is taken as a line start; otherwise only edges in the window.
    assign w_load       = (r_state == UNLOCKED) ? w_fall : w_acc;
    assign w_close      = (r_h == W_CLOSE) && !r_edge_seen;
    assign w_h_cnt      = (r_h == 9'd511) ? 9'd128 : r_h + 9'd1;
    assign w_h_next     = w_load ? H_EDGE_VAL : w_h_cnt;
    assign w_wrap       = !w_load && (r_h == 9'd511);
    // r_line_done blocks a second V increment when a late edge pulls H back to the edge value.
    assign w_line_start = (w_h_next == H_EDGE_VAL) && !r_line_done;
    assign w_norm       = w_rise && (r_run > EQ_M) && (r_run < BR_M);
    // The run counter is about to reach BROAD_MIN on this tick.
    assign w_vtrig      = !i_CSYNC && !w_fall && (r_run == BR_M1) && !r_broad_seen && (r_state != UNLOCKED);
    assign w_good_inc   = r_good + CW'(1);
    assign w_miss_inc   = r_miss + CW'(1);

    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        w_miss_next  = r_miss;
        case (r_state)
            UNLOCKED: if (w_fall) begin
                w_state_next = ACQUIRE;
                w_good_next  = CW'(1);
            end
            ACQUIRE: if (w_acc) begin
                w_good_next  = w_good_inc;
                w_state_next = (w_good_inc == LC) ? LOCKED : ACQUIRE;
            end else if (w_close) begin
                w_state_next = UNLOCKED;
                w_good_next  = '0;
            end
            LOCKED: if (w_acc) begin
                w_miss_next  = '0;
            end else if (w_close) begin
                w_miss_next  = (w_miss_inc == LC) ? '0 : w_miss_inc;
                w_good_next  = (w_miss_inc == LC) ? '0 : r_good;
                w_state_next = (w_miss_inc == LC) ? UNLOCKED : LOCKED;
            end
            default: w_state_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_MRST) begin
            r_state      <= UNLOCKED;
            r_good       <= '0;
            r_miss       <= '0;
            r_sync_prev  <= 1'b1;
            r_run        <= '0;
            r_h          <= 9'd128;
            r_v          <= 9'd248;
            r_edge_seen  <= 1'b0;
            r_line_done  <= 1'b0;
            r_broad_seen <= 1'b0;
            r_vstart     <= 1'b0;
            r_parity     <= 1'b0;
        end else if (w_ce) begin
            r_state      <= w_state_next;
            r_good       <= w_good_next;
            r_miss       <= w_miss_next;
            r_sync_prev  <= i_CSYNC;
            r_run        <= w_fall ? '0 : (!i_CSYNC && r_run != 8'hFF) ? r_run + 8'd1 : r_run;
            r_h          <= w_h_next;
            r_v          <= w_vtrig ? 9'd248 : !w_line_start ? r_v : (r_v == 9'd511) ? 9'd248 : r_v + 9'd1;
            r_edge_seen  <= w_load ? 1'b1 : w_wrap ? 1'b0 : r_edge_seen;
            r_line_done  <= w_line_start ? 1'b1 : w_wrap ? 1'b0 : r_line_done;
            r_broad_seen <= w_vtrig ? 1'b1 : w_norm ? 1'b0 : r_broad_seen;
            r_vstart     <= w_vtrig;
            r_parity     <= r_parity ^ w_vtrig;
        end
    end

    assign o_HCNTR       = r_h;
    assign o_VCNTR       = r_v;
    assign o_HBLANK_n    = r_h[8];
    assign o_VBLANK_n    = (r_v >= 9'd272) && (r_v <= 9'd495);
    assign o_HSYNC_n     = !((r_h >= H_EDGE_VAL) && (r_h <= HS_END));
    assign o_VSYNC_n     = r_v[8];
    assign o_VSTART      = r_vstart;
    assign o_FRAMEPARITY = r_parity;
    assign o_LOCKED      = (r_state == LOCKED);
endmodule

// File: tb/tb_csync_decoder.sv
// tb_csync_decoder: directed scenario bench for csync_decoder
module tb_csync_decoder;
    logic       mclk = 1'b0;
    logic       mrst, cen_n, csync;
    logic [8:0] hcntr, vcntr;
    logic       hblank_n, vblank_n, hsync_n, vsync_n, vstart, parity, locked;
    int         n_chk = 0, n_fail = 0;
    logic [8:0] l_h0, l_v0, l_vs_h, l_vs_v;
    logic       l_lk0, l_hs0, l_vb0, l_vsn0, l_lk_end, l_par;
    int         l_jumps, l_vs_cnt, l_hb_cnt, l_hs_cnt, l_lk_fall, vs_tot;

    csync_decoder dut (
        .i_EMU_MCLK(mclk), .i_MRST(mrst), .i_EMU_CLK6MPCEN_n(cen_n), .i_CSYNC(csync),
        .o_HCNTR(hcntr), .o_VCNTR(vcntr), .o_HBLANK_n(hblank_n), .o_VBLANK_n(vblank_n),
        .o_HSYNC_n(hsync_n), .o_VSYNC_n(vsync_n), .o_VSTART(vstart),
        .o_FRAMEPARITY(parity), .o_LOCKED(locked)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // One line of csync: low for p<lo, optional half-line pulse of width half at p=192.
    task automatic run_line(input int lo, input int half, input int len);
        logic [8:0] hp;
        logic       lk;
        hp = hcntr;
        l_jumps = 0; l_vs_cnt = 0; l_hb_cnt = 0; l_hs_cnt = 0; l_lk_fall = -1; l_vs_h = '0; l_vs_v = '0;
        for (int p = 0; p < len; p++) begin
            lk = locked;
            csync = ((p < lo) || (half > 0 && p >= 192 && p < 192 + half)) ? 1'b0 : 1'b1;
            tick();
            if (p == 0) begin
                l_h0 = hcntr; l_v0 = vcntr; l_lk0 = locked; l_hs0 = hsync_n; l_vb0 = vblank_n; l_vsn0 = vsync_n;
            end
            if (hcntr != ((hp == 9'd511) ? 9'd128 : hp + 9'd1)) l_jumps++;
            if (hblank_n) l_hb_cnt++;
            if (!hsync_n) l_hs_cnt++;
            if (vstart) begin l_vs_cnt++; l_vs_h = hcntr; l_vs_v = vcntr; end
            if (lk && !locked) l_lk_fall = p;
            hp = hcntr;
        end
        l_lk_end = locked;
        l_par = parity;
    endtask

    task automatic frame_line(input int k);
        if (k >= 3 && k <= 5) run_line(160, 160, 384);
        else if (k < 9) run_line(16, 16, 384);
        else run_line(32, 0, 384);
    endtask

    task automatic test_reset();
        mrst = 1'b1; cen_n = 1'b0; csync = 1'b1;
        tick(); tick();
        mrst = 1'b0;
        n_chk++; if (hcntr !== 9'd128) begin n_fail++; $display("FAIL reset_h: got %0d want 128", hcntr); end
        n_chk++; if (vcntr !== 9'd248) begin n_fail++; $display("FAIL reset_v: got %0d want 248", vcntr); end
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_chk++; if (parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b want 0", parity); end
        n_chk++; if (vstart !== 1'b0) begin n_fail++; $display("FAIL reset_vstart: got %b want 0", vstart); end
        n_chk++; if (hblank_n !== 1'b0) begin n_fail++; $display("FAIL reset_hblank: got %b want 0", hblank_n); end
        n_chk++; if (vblank_n !== 1'b0) begin n_fail++; $display("FAIL reset_vblank: got %b want 0", vblank_n); end
        n_chk++; if (vsync_n !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b want 0", vsync_n); end
        n_chk++; if (hsync_n !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", hsync_n); end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 6; i++) begin
            run_line(32, 0, 384);
            if (i == 0) begin
                n_chk++; if (l_h0 !== 9'd176) begin n_fail++; $display("FAIL lock_first_h: got %0d want 176", l_h0); end
                n_chk++; if (l_lk0 !== 1'b0) begin n_fail++; $display("FAIL lock_first_locked: got %b want 0", l_lk0); end
            end
            if (i == 2) begin
                n_chk++; if (l_lk0 !== 1'b0) begin n_fail++; $display("FAIL lock_line3_locked: got %b want 0", l_lk0); end
            end
            if (i == 3) begin
                n_chk++; if (l_lk0 !== 1'b1) begin n_fail++; $display("FAIL lock_line4_locked: got %b want 1", l_lk0); end
                n_chk++; if (l_v0 !== 9'd252) begin n_fail++; $display("FAIL lock_line4_v: got %0d want 252", l_v0); end
            end
            if (i == 5) begin
                n_chk++; if (l_jumps != 0) begin n_fail++; $display("FAIL lock_reloads: got %0d want 0", l_jumps); end
                n_chk++; if (l_h0 !== 9'd176) begin n_fail++; $display("FAIL lock_edge_h: got %0d want 176", l_h0); end
                n_chk++; if (l_hs0 !== 1'b0) begin n_fail++; $display("FAIL lock_hsync_at_edge: got %b want 0", l_hs0); end
                n_chk++; if (l_hs_cnt != 32) begin n_fail++; $display("FAIL lock_hsync_width: got %0d want 32", l_hs_cnt); end
                n_chk++; if (l_hb_cnt != 256) begin n_fail++; $display("FAIL lock_hblank_width: got %0d want 256", l_hb_cnt); end
            end
        end
    endtask

    task automatic test_phase_small();
        run_line(32, 0, 387);
        run_line(32, 0, 384);
        n_chk++; if (l_h0 !== 9'd176) begin n_fail++; $display("FAIL ph3_h: got %0d want 176", l_h0); end
        n_chk++; if (l_lk0 !== 1'b1) begin n_fail++; $display("FAIL ph3_locked: got %b want 1", l_lk0); end
        n_chk++; if (l_v0 !== 9'd256) begin n_fail++; $display("FAIL ph3_v_once: got %0d want 256", l_v0); end
        n_chk++; if (l_jumps != 1) begin n_fail++; $display("FAIL ph3_realign: got %0d want 1", l_jumps); end
        run_line(32, 0, 384);
        n_chk++; if (l_v0 !== 9'd257) begin n_fail++; $display("FAIL ph3_next_v: got %0d want 257", l_v0); end
    endtask

    task automatic test_phase_large();
        run_line(32, 0, 434);
        for (int e = 1; e <= 7; e++) begin
            run_line(32, 0, 384);
            if (e == 1) begin
                n_chk++; if (l_h0 !== 9'd226) begin n_fail++; $display("FAIL ph50_ignored_h: got %0d want 226", l_h0); end
                n_chk++; if (l_jumps != 0) begin n_fail++; $display("FAIL ph50_freerun: got %0d want 0", l_jumps); end
            end
            if (e == 2) begin
                n_chk++; if (l_lk_end !== 1'b1) begin n_fail++; $display("FAIL ph50_miss3_locked: got %b want 1", l_lk_end); end
            end
            if (e == 3) begin
                n_chk++; if (l_lk_fall != 340) begin n_fail++; $display("FAIL ph50_drop_pos: got %0d want 340", l_lk_fall); end
            end
            if (e == 4) begin
                n_chk++; if (l_h0 !== 9'd176) begin n_fail++; $display("FAIL ph50_reacq_h: got %0d want 176", l_h0); end
                n_chk++; if (l_lk0 !== 1'b0) begin n_fail++; $display("FAIL ph50_reacq_locked: got %b want 0", l_lk0); end
            end
            if (e == 6) begin
                n_chk++; if (l_lk0 !== 1'b0) begin n_fail++; $display("FAIL ph50_good3_locked: got %b want 0", l_lk0); end
            end
            if (e == 7) begin
                n_chk++; if (l_lk0 !== 1'b1) begin n_fail++; $display("FAIL ph50_relock: got %b want 1", l_lk0); end
                n_chk++; if (l_v0 !== 9'd265) begin n_fail++; $display("FAIL ph50_v: got %0d want 265", l_v0); end
            end
        end
    endtask

    task automatic test_hold_high();
        for (int f = 1; f <= 4; f++) begin
            run_line(0, 0, 384);
            if (f == 3) begin
                n_chk++; if (l_lk_end !== 1'b1) begin n_fail++; $display("FAIL hold_miss3_locked: got %b want 1", l_lk_end); end
            end
            if (f == 4) begin
                n_chk++; if (l_lk_fall != 6) begin n_fail++; $display("FAIL hold_drop_pos: got %0d want 6", l_lk_fall); end
                n_chk++; if (l_v0 !== 9'd269) begin n_fail++; $display("FAIL hold_v: got %0d want 269", l_v0); end
                n_chk++; if (l_jumps != 0) begin n_fail++; $display("FAIL hold_freerun: got %0d want 0", l_jumps); end
                n_chk++; if (l_hb_cnt != 256) begin n_fail++; $display("FAIL hold_wrap: got %0d want 256", l_hb_cnt); end
            end
        end
    endtask

    task automatic test_frame();
        vs_tot = 0;
        for (int k = 0; k < 30; k++) begin
            frame_line(k);
            vs_tot += l_vs_cnt;
            if (k == 3) begin
                n_chk++; if (l_vs_cnt != 1) begin n_fail++; $display("FAIL fa_vstart_cnt: got %0d want 1", l_vs_cnt); end
                n_chk++; if (l_vs_h !== 9'd240) begin n_fail++; $display("FAIL fa_vstart_h: got %0d want 240", l_vs_h); end
                n_chk++; if (l_vs_v !== 9'd248) begin n_fail++; $display("FAIL fa_vstart_v: got %0d want 248", l_vs_v); end
                n_chk++; if (l_par !== 1'b1) begin n_fail++; $display("FAIL fa_parity: got %b want 1", l_par); end
            end
            if (k == 5) begin
                n_chk++; if (l_v0 !== 9'd250) begin n_fail++; $display("FAIL fa_broad_halfline_v: got %0d want 250", l_v0); end
            end
            if (k == 8) begin
                n_chk++; if (l_v0 !== 9'd253) begin n_fail++; $display("FAIL fa_eq_halfline_v: got %0d want 253", l_v0); end
            end
            if (k == 10) begin
                n_chk++; if (l_vsn0 !== 1'b0) begin n_fail++; $display("FAIL fa_vsync_255: got %b want 0", l_vsn0); end
            end
            if (k == 11) begin
                n_chk++; if (l_vsn0 !== 1'b1) begin n_fail++; $display("FAIL fa_vsync_256: got %b want 1", l_vsn0); end
            end
            if (k == 26) begin
                n_chk++; if (l_vb0 !== 1'b0) begin n_fail++; $display("FAIL fa_vblank_271: got %b want 0", l_vb0); end
            end
            if (k == 27) begin
                n_chk++; if (l_vb0 !== 1'b1) begin n_fail++; $display("FAIL fa_vblank_272: got %b want 1", l_vb0); end
            end
        end
        n_chk++; if (vs_tot != 1) begin n_fail++; $display("FAIL fa_vstart_total: got %0d want 1", vs_tot); end
        vs_tot = 0;
        for (int k = 0; k < 12; k++) begin
            frame_line(k);
            vs_tot += l_vs_cnt;
            if (k == 3) begin
                n_chk++; if (l_vs_h !== 9'd240) begin n_fail++; $display("FAIL fb_vstart_h: got %0d want 240", l_vs_h); end
                n_chk++; if (l_vs_v !== 9'd248) begin n_fail++; $display("FAIL fb_vstart_v: got %0d want 248", l_vs_v); end
                n_chk++; if (l_par !== 1'b0) begin n_fail++; $display("FAIL fb_parity: got %b want 0", l_par); end
            end
        end
        n_chk++; if (vs_tot != 1) begin n_fail++; $display("FAIL fb_vstart_total: got %0d want 1", vs_tot); end
        for (int k = 0; k < 4; k++) begin
            frame_line(k);
            if (k == 3) begin
                n_chk++; if (l_par !== 1'b1) begin n_fail++; $display("FAIL fc_parity: got %b want 1", l_par); end
            end
        end
    endtask

    task automatic test_enable_hold();
        cen_n = 1'b1; csync = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_chk++; if (hcntr !== 9'd175) begin n_fail++; $display("FAIL en_hold_h: got %0d want 175", hcntr); end
        n_chk++; if (vcntr !== 9'd248) begin n_fail++; $display("FAIL en_hold_v: got %0d want 248", vcntr); end
        cen_n = 1'b0;
        tick();
        n_chk++; if (hcntr !== 9'd176) begin n_fail++; $display("FAIL en_resume_h: got %0d want 176", hcntr); end
        n_chk++; if (vcntr !== 9'd249) begin n_fail++; $display("FAIL en_resume_v: got %0d want 249", vcntr); end
        n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL en_resume_locked: got %b want 1", locked); end
    endtask

    task automatic test_reset_mid();
        mrst = 1'b1; csync = 1'b1;
        tick();
        mrst = 1'b0;
        n_chk++; if (hcntr !== 9'd128) begin n_fail++; $display("FAIL mid_reset_h: got %0d want 128", hcntr); end
        n_chk++; if (vcntr !== 9'd248) begin n_fail++; $display("FAIL mid_reset_v: got %0d want 248", vcntr); end
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_reset_locked: got %b want 0", locked); end
        n_chk++; if (parity !== 1'b0) begin n_fail++; $display("FAIL mid_reset_parity: got %b want 0", parity); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lock();
        test_phase_small();
        test_phase_large();
        test_hold_high();
        test_frame();
        test_enable_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
